// File: rtl/seg7_pkg.sv
// Shared types and the 7-segment glyph table for the hex display sniffer.
package seg7_pkg;

    typedef logic [6:0] seg_t;              // {g,f,e,d,c,b,a}, active-high

    localparam int NUM_DIGITS = 4;
    localparam int DIG_IDX_W  = 2;

    localparam seg_t SEG_BLANK = 7'h00;

    // Glyph for each nibble value 0..F (lower-case b and d on the display).
    localparam seg_t SEG_HEX [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg_7_dec.sv
// Reverse 7-segment decoder: maps a lit-segment pattern back to its hex nibble.
module seg_7_dec
    import seg7_pkg::*;
(
    input  seg_t       seg_i,
    output logic       hit_o,
    output logic       blank_o,
    output logic [3:0] nibble_o
);

    // Table search; at most one entry can match since all glyphs are distinct.
    always_comb begin
        hit_o    = 1'b0;
        nibble_o = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (seg_i == SEG_HEX[i]) begin
                hit_o    = 1'b1;
                nibble_o = 4'(i);
            end
        end
        blank_o = (seg_i == SEG_BLANK);
    end

endmodule

// File: rtl/seg_7_hex_capture.sv
// Sniffs a multiplexed 4-digit 7-segment bus, debounces each digit, decodes it
// and publishes a 16-bit frame through a valid/ready handshake once all four
// digits have been captured. STABLE_CYC must be at least 2.
module seg_7_hex_capture
    import seg7_pkg::*;
#(
    parameter int STABLE_CYC     = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg_in,
    input  logic [3:0]  com_in,
    output logic [15:0] out_data,
    output logic [3:0]  out_blank,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        err_pattern,
    output logic        overrun,
    input  logic        clr_err
);

    localparam int CNT_W = $clog2(STABLE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(STABLE_CYC - 1);

    logic [10:0] bus_raw;
    logic [10:0] sync1_q, sync2_q, prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        same, accept;

    logic [3:0]  com_s;
    seg_t        seg_s;
    logic        dec_hit, dec_blank;
    logic [3:0]  dec_nibble;
    logic        onehot;
    logic [DIG_IDX_W-1:0] dig_idx;

    logic [15:0] slot_q, slot_d;
    logic [3:0]  blank_q, blank_d;
    logic [3:0]  seen_q, seen_d;
    logic [15:0] out_data_q, out_data_d;
    logic [3:0]  out_blank_q, out_blank_d;
    logic        out_valid_q, out_valid_d;
    logic        err_q, err_d, ovr_q, ovr_d;
    logic        frame_done, load, err_set, ovr_set;

    // Common-anode boards drive both buses inverted; normalise before syncing.
    assign bus_raw = SEG_ACTIVE_LOW ? ~{com_in, seg_in} : {com_in, seg_in};

    assign com_s = sync2_q[10:7];
    assign seg_s = sync2_q[6:0];

    // Accept exactly once, in the cycle the run of identical samples saturates the counter.
    assign same   = (sync2_q == prev_q);
    assign accept = same && (cnt_q == CNT_PRE);

    // Stability counter: clear on any change, otherwise count up to saturation.
    always_comb begin
        cnt_d = cnt_q;
        if (!same)
            cnt_d = '0;
        else if (cnt_q != CNT_MAX)
            cnt_d = cnt_q + 1'b1;
    end

    seg_7_dec u_dec (
        .seg_i    (seg_s),
        .hit_o    (dec_hit),
        .blank_o  (dec_blank),
        .nibble_o (dec_nibble)
    );

    // Digit select must be strictly one-hot; anything else is bus turnover noise.
    always_comb begin
        onehot  = 1'b1;
        dig_idx = '0;
        case (com_s)
            4'b0001: dig_idx = 2'd0;
            4'b0010: dig_idx = 2'd1;
            4'b0100: dig_idx = 2'd2;
            4'b1000: dig_idx = 2'd3;
            default: onehot  = 1'b0;
        endcase
    end

    // Slot capture, frame completion, handshake and sticky flag next-state.
    always_comb begin
        slot_d      = slot_q;
        blank_d     = blank_q;
        seen_d      = seen_q;
        out_data_d  = out_data_q;
        out_blank_d = out_blank_q;
        out_valid_d = out_valid_q;
        err_set     = 1'b0;

        frame_done = (seen_q == 4'hF);
        load       = frame_done && (!out_valid_q || out_ready);
        ovr_set    = frame_done && !load;

        // A completed frame always restarts collection, whether published or dropped.
        if (frame_done)
            seen_d = 4'h0;

        if (accept && onehot) begin
            if (dec_hit || dec_blank) begin
                slot_d[{dig_idx, 2'b00} +: 4] = dec_hit ? dec_nibble : 4'h0;
                blank_d[dig_idx]              = dec_blank;
                seen_d[dig_idx]               = 1'b1;
            end else begin
                err_set = 1'b1;
            end
        end

        if (load) begin
            out_data_d  = slot_q;
            out_blank_d = blank_q;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        err_d = err_set ? 1'b1 : (clr_err ? 1'b0 : err_q);
        ovr_d = ovr_set ? 1'b1 : (clr_err ? 1'b0 : ovr_q);
    end

    // State registers; reset drops any partial or pending frame at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            prev_q      <= '0;
            cnt_q       <= '0;
            slot_q      <= '0;
            blank_q     <= '0;
            seen_q      <= '0;
            out_data_q  <= '0;
            out_blank_q <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            sync1_q     <= bus_raw;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            cnt_q       <= cnt_d;
            slot_q      <= slot_d;
            blank_q     <= blank_d;
            seen_q      <= seen_d;
            out_data_q  <= out_data_d;
            out_blank_q <= out_blank_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            ovr_q       <= ovr_d;
        end
    end

    assign out_data    = out_data_q;
    assign out_blank   = out_blank_q;
    assign out_valid   = out_valid_q;
    assign err_pattern = err_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_seg_7_hex_capture.sv
// Directed bench for seg_7_hex_capture: an active-high and an active-low build
// watch the same logical bus (the second one sees it inverted).
module tb_seg_7_hex_capture;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg_b = 7'h00;
    logic [3:0]  com_b = 4'h0;
    logic        out_ready = 1'b1;
    logic        clr_err = 1'b0;

    logic [15:0] out_data,  out_data_n;
    logic [3:0]  out_blank, out_blank_n;
    logic        out_valid, out_valid_n;
    logic        err_p,     err_p_n;
    logic        ovr,       ovr_n;

    logic [6:0]  seg_inv;
    logic [3:0]  com_inv;
    assign seg_inv = ~seg_b;
    assign com_inv = ~com_b;

    always #5 clk = ~clk;

    seg_7_hex_capture #(.STABLE_CYC(4), .SEG_ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_b), .com_in(com_b),
        .out_data(out_data), .out_blank(out_blank), .out_valid(out_valid),
        .out_ready(out_ready), .err_pattern(err_p), .overrun(ovr), .clr_err(clr_err)
    );

    seg_7_hex_capture #(.STABLE_CYC(4), .SEG_ACTIVE_LOW(1'b1)) dut_n (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_inv), .com_in(com_inv),
        .out_data(out_data_n), .out_blank(out_blank_n), .out_valid(out_valid_n),
        .out_ready(out_ready), .err_pattern(err_p_n), .overrun(ovr_n), .clr_err(clr_err)
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    // Handshake monitor, sampling just before each rising edge.
    int          frames = 0, frames_n = 0, valid_cyc = 0;
    logic [15:0] last_data = '0, last_data_n = '0;
    logic [3:0]  last_blank = '0, last_blank_n = '0;

    always begin
        @(negedge clk);
        #4;
        if (rst_n) begin
            if (out_valid) valid_cyc++;
            if (out_valid && out_ready) begin
                frames++;
                last_data  = out_data;
                last_blank = out_blank;
            end
            if (out_valid_n && out_ready) begin
                frames_n++;
                last_data_n  = out_data_n;
                last_blank_n = out_blank_n;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic [3:0] com, input logic [6:0] seg, input int n);
        com_b = com;
        seg_b = seg;
        repeat (n) @(negedge clk);
    endtask

    // segs packs {d3,d2,d1,d0}, each 7 bits.
    task automatic show_digits(input logic [27:0] segs, input logic [3:0] mask);
        for (int d = 0; d < 4; d++)
            if (mask[d]) drive(4'(1 << d), segs[d*7 +: 7], 10);
    endtask

    typedef struct packed {
        logic [27:0] segs;
        logic [15:0] data;
        logic [3:0]  blank;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int f0, fn0, v0;

        vecs[0] = '{segs: {7'h66, 7'h4F, 7'h5B, 7'h06}, data: 16'h4321, blank: 4'b0000};
        vecs[1] = '{segs: {7'h7F, 7'h00, 7'h7F, 7'h7F}, data: 16'h8088, blank: 4'b0100};
        vecs[2] = '{segs: {7'h07, 7'h7D, 7'h6D, 7'h3F}, data: 16'h7650, blank: 4'b0000};
        vecs[3] = '{segs: {7'h7C, 7'h77, 7'h6F, 7'h7F}, data: 16'hBA98, blank: 4'b0000};
        vecs[4] = '{segs: {7'h71, 7'h79, 7'h5E, 7'h39}, data: 16'hFEDC, blank: 4'b0000};
        vecs[5] = '{segs: {7'h00, 7'h00, 7'h00, 7'h00}, data: 16'h0000, blank: 4'b1111};

        // Reset state
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'h0);
        chk("rst_flags", {30'd0, err_p, ovr}, 32'd0);
        chk("rst_valid_n", 32'(out_valid_n), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        drive(4'h0, 7'h00, 10);

        // Table-driven frames with the consumer always ready
        for (int v = 0; v < 6; v++) begin
            f0 = frames; fn0 = frames_n; v0 = valid_cyc;
            show_digits(vecs[v].segs, 4'hF);
            repeat (3) @(negedge clk);
            chk($sformatf("v%0d_frames", v), 32'(frames - f0), 32'd1);
            chk($sformatf("v%0d_data", v), 32'(last_data), 32'(vecs[v].data));
            chk($sformatf("v%0d_blank", v), 32'(last_blank), 32'(vecs[v].blank));
            chk($sformatf("v%0d_valid_1clk", v), 32'(valid_cyc - v0), 32'd1);
            chk($sformatf("v%0d_frames_n", v), 32'(frames_n - fn0), 32'd1);
            chk($sformatf("v%0d_data_n", v), 32'(last_data_n), 32'(vecs[v].data));
            chk($sformatf("v%0d_blank_n", v), 32'(last_blank_n), 32'(vecs[v].blank));
        end
        chk("tbl_err", {30'd0, err_p, ovr}, 32'd0);

        // Glitch: each digit held only 3 clocks, must never be accepted
        f0 = frames; v0 = valid_cyc;
        for (int r = 0; r < 3; r++)
            for (int d = 0; d < 4; d++)
                drive(4'(1 << d), (d == 3) ? 7'h5B : 7'h06, 3);
        drive(4'h0, 7'h00, 10);
        chk("glitch_frames", 32'(frames - f0), 32'd0);
        chk("glitch_valid", 32'(valid_cyc - v0), 32'd0);
        // Digits 0..2 alone must not complete a frame if digit 3 was never seen
        show_digits({7'h00, 7'h06, 7'h06, 7'h06}, 4'b0111);
        repeat (3) @(negedge clk);
        chk("glitch_seen", 32'(frames - f0), 32'd0);
        show_digits({7'h5B, 7'h00, 7'h00, 7'h00}, 4'b1000);
        repeat (3) @(negedge clk);
        chk("glitch_done_frames", 32'(frames - f0), 32'd1);
        chk("glitch_done_data", 32'(last_data), 32'h2111);

        // Bad pattern on digit 1 blocks the frame until it shows valid hex
        f0 = frames;
        show_digits({7'h4F, 7'h5B, 7'h49, 7'h3F}, 4'hF);
        repeat (3) @(negedge clk);
        chk("bad_err", 32'(err_p), 32'd1);
        chk("bad_noframe", 32'(frames - f0), 32'd0);
        show_digits({7'h00, 7'h00, 7'h06, 7'h00}, 4'b0010);
        repeat (3) @(negedge clk);
        chk("bad_fix_frames", 32'(frames - f0), 32'd1);
        chk("bad_fix_data", 32'(last_data), 32'h3210);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("clr_err", 32'(err_p), 32'd0);

        // Stalled consumer: second frame is dropped and flagged
        out_ready = 1'b0;
        f0 = frames;
        show_digits({7'h06, 7'h5B, 7'h4F, 7'h66}, 4'hF);
        repeat (3) @(negedge clk);
        chk("stall1_valid", 32'(out_valid), 32'd1);
        chk("stall1_data", 32'(out_data), 32'h1234);
        chk("stall1_ovr", 32'(ovr), 32'd0);
        show_digits({7'h6D, 7'h7D, 7'h07, 7'h7F}, 4'hF);
        repeat (3) @(negedge clk);
        chk("stall2_data", 32'(out_data), 32'h1234);
        chk("stall2_ovr", 32'(ovr), 32'd1);
        chk("stall2_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("stall_accept_valid", 32'(out_valid), 32'd0);
        chk("stall_accept_frames", 32'(frames - f0), 32'd1);
        chk("stall_accept_data", 32'(last_data), 32'h1234);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("clr_ovr", 32'(ovr), 32'd0);

        // Non-one-hot select is ignored, even with a non-hex pattern
        f0 = frames;
        drive(4'b0011, 7'h49, 12);
        chk("com0011_err", 32'(err_p), 32'd0);
        chk("com0011_frames", 32'(frames - f0), 32'd0);

        // Async reset with a pending frame and a sticky flag set
        out_ready = 1'b0;
        drive(4'b0010, 7'h49, 10);
        show_digits(vecs[0].segs, 4'hF);
        repeat (3) @(negedge clk);
        chk("prerst_valid", 32'(out_valid), 32'd1);
        chk("prerst_err", 32'(err_p), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out", {out_data, out_blank, out_valid, err_p, ovr}, 32'h0);
        chk("midrst_out_n", {out_data_n, out_blank_n, out_valid_n, err_p_n, ovr_n}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("postrst_valid", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
